dsc_roberts_window_sequencer: RTL
=================================

# dsc_roberts_window_sequencer

Upstream feeder and controller for the serial stochastic Roberts-cross core. The block takes a raster-order pixel stream and keeps one image row plus one pixel in a shift-register line buffer. For every valid 2x2 window it loads four binary pixels into the core, clears the core, enables it until the core signals done, then presents the core's binary result on a ready/valid output port. One kernel runs at a time; the input stream stalls while a kernel is in flight.

## Interface
- DATA_WIDTH, 5, pixel width in bits and width of the core result
- IMG_WIDTH, 8, pixels per row (>= 2)
- IMG_HEIGHT, 8, rows per frame (>= 2)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous active-low reset
- pix_in  in  DATA_WIDTH  input pixel, raster order
- pix_valid  in  1  pix_in valid
- pix_ready  out  1  block can accept a pixel
- kern_in00, kern_in01, kern_in10, kern_in11  out  DATA_WIDTH each  window to core: (r-1,c-1), (r-1,c), (r,c-1), (r,c)
- kern_rst  out  1  core reset, active-low, pulsed for one cycle per window
- kern_en  out  1  core enable
- kern_result  in  DATA_WIDTH  core binary output
- kern_done  in  1  core done
- out_data  out  DATA_WIDTH  captured gradient result
- out_row, out_col  out  $clog2(IMG_HEIGHT), $clog2(IMG_WIDTH)  coordinate (r,c) of the window's bottom-right pixel
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- frame_done  out  1  one-cycle pulse after the last window result of a frame is accepted

## Operation
- Line buffer: shift register sr[0..IMG_WIDTH] of DATA_WIDTH. On accept, sr[0]<=pix_in and sr[i]<=sr[i-1].
- Accept = pix_valid & pix_ready. On accept of pixel (r,c) with r>=1 and c>=1, the window registers latch in11=pix_in, in10=sr[0], in01=sr[IMG_WIDTH-1], in00=sr[IMG_WIDTH]. kern_in* are driven from these registers and stay stable until the next window is latched.
- Position counters col/row advance on every accept. col wraps at IMG_WIDTH-1 and increments row. row wraps at IMG_HEIGHT-1 to 0, and the line buffer contents are not cleared at frame wrap.
- FSM states:
  - IDLE: pix_ready=1. On accept with r>=1 and c>=1, go to CLEAR. Otherwise stay in IDLE.
  - CLEAR: one cycle, kern_rst=0, then go to RUN.
  - RUN: kern_en=1. When kern_done=1, capture kern_result into out_data and go to OUT.
  - OUT: out_valid=1. When out_ready=1, go to IDLE. If this window is (IMG_HEIGHT-1, IMG_WIDTH-1), pulse frame_done on the following cycle.
- kern_done is ignored outside RUN. kern_rst=1 in every state except CLEAR.
- pix_ready=0 in CLEAR, RUN and OUT.
- Windows per frame: (IMG_WIDTH-1)*(IMG_HEIGHT-1). Row 0 and column 0 pixels produce no output.
- out_data, out_row and out_col are held stable while out_valid=1 and out_ready=0.

## Timing
- Reset (rst=0, asynchronous) forces:
  - state=IDLE, row=col=0
  - sr, window registers, out_data, out_row, out_col = 0
  - pix_ready=1, kern_en=0, kern_rst=1, out_valid=0, frame_done=0
- Reset mid-kernel abandons the window. No output and no frame_done are produced for it.
- Accept in cycle t, for a window pixel:
  - CLEAR in t+1
  - kern_en=1 from t+2
  - kern_done sampled high in cycle k (k >= t+2)
  - out_valid=1 from k+1
- kern_done high in the first RUN cycle is legal; out_valid is then high at t+3.
- Handshake completes in the cycle where out_valid & out_ready are both high. The next pixel can be accepted in the following cycle.
- Minimum spacing between window pixels is 4 cycles plus the kernel run time.
- kern_en drops in the cycle after kern_done is sampled.

## Test plan
- Reset with IMG_WIDTH=3, IMG_HEIGHT=3 -> all outputs at reset values; pix_ready=1, kern_rst=1.
- Stream pixels 0..8 with pix_valid held high, behavioural core returning done 5 cycles after en rises and result=in00+in11, out_ready=1:
  - exactly 4 results at (1,1),(1,2),(2,1),(2,2)
  - out_data = 4, 6, 10, 12
  - frame_done pulses once after (2,2)
  - pix_ready low during each kernel
- Same stream with out_ready held low 10 cycles on the second result -> out_data=6 and coordinate stable throughout; no pixel accepted until release.
- Core asserts kern_done in the first RUN cycle -> out_valid at accept+3; kern_en high for exactly 1 cycle.
- Assert rst=0 during RUN of window (1,2), then restream the frame -> first output is (1,1) with fresh data; no stale out_valid.
- Two back-to-back 3x3 frames, second frame pixels 9..17 -> 8 results total, frame_done pulses twice; second-frame (1,1) result is 9+13=22.

Source files
------------

// File: rtl/dsc_roberts_window_sequencer.sv
// dsc_roberts_window_sequencer: line-buffered 2x2 window feeder and run/handshake controller
// for the serial stochastic Roberts-cross core.
module dsc_roberts_window_sequencer #(
    parameter int DATA_WIDTH = 5,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    localparam int RW = $clog2(IMG_HEIGHT),
    localparam int CW = $clog2(IMG_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pix_in,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    output logic [DATA_WIDTH-1:0] kern_in00,
    output logic [DATA_WIDTH-1:0] kern_in01,
    output logic [DATA_WIDTH-1:0] kern_in10,
    output logic [DATA_WIDTH-1:0] kern_in11,
    output logic                  kern_rst,
    output logic                  kern_en,
    input  logic [DATA_WIDTH-1:0] kern_result,
    input  logic                  kern_done,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [RW-1:0]         out_row,
    output logic [CW-1:0]         out_col,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_done
);
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, OUT} state_t;

    state_t state, state_nx;
    logic [DATA_WIDTH-1:0] sr [0:IMG_WIDTH];
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic accept, col_end, last;

    assign pix_ready = state == IDLE;
    assign kern_rst  = state != CLEAR;
    assign kern_en   = state == RUN;
    assign out_valid = state == OUT;
    assign accept    = pix_valid && pix_ready;
    assign col_end   = col == CW'(IMG_WIDTH - 1);
    assign last      = out_row == RW'(IMG_HEIGHT - 1) && out_col == CW'(IMG_WIDTH - 1);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = accept && row != '0 && col != '0 ? CLEAR : IDLE;
            CLEAR: state_nx = RUN;
            RUN:   state_nx = kern_done ? OUT : RUN;
            OUT:   state_nx = out_ready ? IDLE : OUT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            sr         <= '{default: '0};
            kern_in00  <= '0;
            kern_in01  <= '0;
            kern_in10  <= '0;
            kern_in11  <= '0;
            out_data   <= '0;
            out_row    <= '0;
            out_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            frame_done <= state == OUT && out_ready && last;
            if (state == RUN && kern_done)
                out_data <= kern_result;
            if (accept) begin
                sr[0] <= pix_in;
                for (int i = 1; i <= IMG_WIDTH; i++)
                    sr[i] <= sr[i-1];
                col <= col_end ? '0 : col + 1'b1;
                if (col_end)
                    row <= row == RW'(IMG_HEIGHT - 1) ? '0 : row + 1'b1;
                // the window's coordinate is latched with its pixels so it stays valid through OUT
                if (row != '0 && col != '0) begin
                    kern_in11 <= pix_in;
                    kern_in10 <= sr[0];
                    kern_in01 <= sr[IMG_WIDTH-1];
                    kern_in00 <= sr[IMG_WIDTH];
                    out_row   <= row;
                    out_col   <= col;
                end
            end
        end
    end
endmodule
